// File: rtl/axis_fifo_pkg.sv
// Shared types and width helpers for the AXI-Stream FIFO control slice.
package axis_fifo_pkg;

   // Write-side frame state: passing words into storage, or discarding the rest of a frame.
   typedef enum logic {
      FS_PASS = 1'b0,
      FS_DROP = 1'b1
   } frame_state_e;

   // Address width that stays at least one bit for degenerate depths.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Pointers carry one extra wrap bit above the address.
   function automatic int ptr_width(input int els);
      return safe_clog2(els) + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_valid_pipe.sv
// Per-stage valid tracking for the storage read pipeline.
// valid[j] set means storage stage j currently holds a word.
module axis_fifo_valid_pipe #(
   parameter int stages_p = 1
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                ready_i,
   input  logic                r_v_i,
   output logic                stage0_free_o,
   output logic [stages_p-1:0] valid_o
);

   logic [stages_p-1:0] valid_q, valid_d, adv;
   logic                carry;

   // Ready ripples back from the output: a stage may load when it is empty or its word moves on.
   always_comb begin
      carry = ready_i;
      adv   = '0;
      for (int j = stages_p - 1; j >= 0; j--) begin
         carry  = carry | ~valid_q[j];
         adv[j] = carry;
      end
   end

   assign stage0_free_o = adv[0];

   // Next valid vector: stage 0 takes the new read, later stages take their predecessor.
   always_comb begin
      valid_d = valid_q;
      if (adv[0]) valid_d[0] = r_v_i;
      for (int j = 1; j < stages_p; j++) begin
         if (adv[j]) valid_d[j] = valid_q[j-1];
      end
   end

   // Valid register.
   always_ff @(posedge clk_i) begin
      if (reset_i) valid_q <= '0;
      else         valid_q <= valid_d;
   end

   assign valid_o = valid_q;

endmodule

// File: rtl/axis_fifo_ctrl.sv
// Pointer, handshake and read-pipeline control for the AXI-Stream FIFO.
// Data bypasses this block; it only steers the storage stage.
module axis_fifo_ctrl
   import axis_fifo_pkg::*;
#(
   parameter int  els_p             = 16,
   parameter int  pipeline_output_p = 1,
   parameter bit  frame_mode_p      = 1'b0,
   localparam int addr_width_lp     = safe_clog2(els_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         s_tvalid_i,
   output logic                         s_tready_o,
   input  logic                         s_tlast_i,
   input  logic                         s_tuser_i,
   output logic                         m_tvalid_o,
   input  logic                         m_tready_i,
   output logic                         mem_w_v_o,
   output logic [addr_width_lp-1:0]     mem_w_addr_o,
   output logic                         mem_r_v_o,
   output logic [addr_width_lp-1:0]     mem_r_addr_o,
   output logic                         mem_output_ready_o,
   output logic [pipeline_output_p-1:0] mem_valid_pipe_o,
   output logic [addr_width_lp:0]       count_o,
   output logic                         drop_o
);

   localparam int ptr_width_lp = ptr_width(els_p);
   typedef logic [ptr_width_lp-1:0] ptr_t;

   ptr_t         wr_ptr_q, wr_ptr_d;
   ptr_t         wr_commit_q, wr_commit_d;
   ptr_t         rd_ptr_q, rd_ptr_d;
   frame_state_e fs_q, fs_d;
   logic         full, empty, accept, stage0_free;

   // Occupancy counts everything written and not yet read, committed or not.
   assign full       = (wr_ptr_q - rd_ptr_q) == ptr_t'(els_p);
   assign empty      = (wr_commit_q == rd_ptr_q);
   assign s_tready_o = frame_mode_p ? 1'b1 : ~full;
   assign accept     = s_tvalid_i & s_tready_o;

   // Write side: store words, commit good frames at tlast, rewind on a bad or overflowing frame.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      fs_d        = fs_q;
      mem_w_v_o   = 1'b0;
      drop_o      = 1'b0;
      if (accept) begin
         if (!full && fs_q == FS_PASS) begin
            mem_w_v_o = 1'b1;
            wr_ptr_d  = wr_ptr_q + ptr_t'(1);
         end else if (frame_mode_p) begin
            fs_d = FS_DROP;
         end
         if (frame_mode_p && s_tlast_i) begin
            // A frame that lost any word (full) is as bad as one flagged by tuser.
            if (s_tuser_i || fs_q == FS_DROP || full) begin
               wr_ptr_d = wr_commit_q;
               drop_o   = 1'b1;
               fs_d     = FS_PASS;
            end else begin
               wr_commit_d = wr_ptr_q + ptr_t'(1);
            end
         end
      end
      if (!frame_mode_p) wr_commit_d = wr_ptr_d;
   end

   // Read pipeline occupancy.
   axis_fifo_valid_pipe #(
      .stages_p (pipeline_output_p)
   ) u_vpipe (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .ready_i       (m_tready_i),
      .r_v_i         (mem_r_v_o),
      .stage0_free_o (stage0_free),
      .valid_o       (mem_valid_pipe_o)
   );

   assign mem_r_v_o = ~empty & stage0_free;
   assign rd_ptr_d  = rd_ptr_q + ptr_t'(mem_r_v_o);

   // Pointer and frame-state registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         rd_ptr_q    <= '0;
         fs_q        <= FS_PASS;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         rd_ptr_q    <= rd_ptr_d;
         fs_q        <= fs_d;
      end
   end

   assign mem_w_addr_o       = wr_ptr_q[addr_width_lp-1:0];
   assign mem_r_addr_o       = rd_ptr_q[addr_width_lp-1:0];
   assign mem_output_ready_o = m_tready_i;
   assign m_tvalid_o         = mem_valid_pipe_o[pipeline_output_p-1];
   assign count_o            = wr_commit_q - rd_ptr_q;

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Bench for axis_fifo_ctrl: depth 8, two read stages, word and frame mode instances.
module tb_axis_fifo_ctrl;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic fm = 1'b0;
   logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, m_tready = 1'b0;

   always #5 clk = ~clk;

   // word-mode instance outputs
   logic       w_trdy, w_tv, w_wv, w_rv, w_ordy, w_drop;
   logic [2:0] w_waddr, w_raddr;
   logic [1:0] w_vp;
   logic [3:0] w_cnt;
   // frame-mode instance outputs
   logic       f_trdy, f_tv, f_wv, f_rv, f_ordy, f_drop;
   logic [2:0] f_waddr, f_raddr;
   logic [1:0] f_vp;
   logic [3:0] f_cnt;

   axis_fifo_ctrl #(.els_p(DEPTH), .pipeline_output_p(2), .frame_mode_p(1'b0)) u_word (
      .clk_i(clk), .reset_i(reset),
      .s_tvalid_i(s_tvalid & ~fm), .s_tready_o(w_trdy),
      .s_tlast_i(s_tlast), .s_tuser_i(s_tuser),
      .m_tvalid_o(w_tv), .m_tready_i(m_tready & ~fm),
      .mem_w_v_o(w_wv), .mem_w_addr_o(w_waddr),
      .mem_r_v_o(w_rv), .mem_r_addr_o(w_raddr),
      .mem_output_ready_o(w_ordy), .mem_valid_pipe_o(w_vp),
      .count_o(w_cnt), .drop_o(w_drop));

   axis_fifo_ctrl #(.els_p(DEPTH), .pipeline_output_p(2), .frame_mode_p(1'b1)) u_frm (
      .clk_i(clk), .reset_i(reset),
      .s_tvalid_i(s_tvalid & fm), .s_tready_o(f_trdy),
      .s_tlast_i(s_tlast), .s_tuser_i(s_tuser),
      .m_tvalid_o(f_tv), .m_tready_i(m_tready & fm),
      .mem_w_v_o(f_wv), .mem_w_addr_o(f_waddr),
      .mem_r_v_o(f_rv), .mem_r_addr_o(f_raddr),
      .mem_output_ready_o(f_ordy), .mem_valid_pipe_o(f_vp),
      .count_o(f_cnt), .drop_o(f_drop));

   // view of whichever instance is under test
   wire       d_trdy  = fm ? f_trdy  : w_trdy;
   wire       d_tv    = fm ? f_tv    : w_tv;
   wire       d_wv    = fm ? f_wv    : w_wv;
   wire       d_rv    = fm ? f_rv    : w_rv;
   wire       d_ordy  = fm ? f_ordy  : w_ordy;
   wire       d_drop  = fm ? f_drop  : w_drop;
   wire [2:0] d_waddr = fm ? f_waddr : w_waddr;
   wire [2:0] d_raddr = fm ? f_raddr : w_raddr;
   wire [1:0] d_vp    = fm ? f_vp    : w_vp;
   wire [3:0] d_cnt   = fm ? f_cnt   : w_cnt;

   int n_chk = 0, n_pass = 0;

   // reference model: committed-unread words, written-uncommitted words, two output slots
   int q_commit[$];
   int q_pend[$];
   bit slot_v[2];
   int slot_id[2];
   bit dropping;
   // bench-side storage and words the DUT has read into its pipeline
   int bmem[DEPTH];
   int dut_q[$];
   int s_id = 0, n_out = 0, n_drop = 0;

   task automatic chk(input string tag, input int act, input int want);
      n_chk++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, want);
   endtask

   task automatic clr_model();
      q_commit.delete(); q_pend.delete(); dut_q.delete();
      slot_v[0] = 0; slot_v[1] = 0; dropping = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; s_tvalid = 0; s_tlast = 0; s_tuser = 0; m_tready = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      clr_model();
   endtask

   // One clock: drive, compare against the model, advance the model.
   task automatic cyc(input bit tv, input bit tl, input bit tu, input bit rdy);
      bit full_m, e_trdy, free1, free0, e_rv, acc, wr, e_drop;
      int got;
      @(posedge clk); #1;
      s_tvalid = tv; s_tlast = tl; s_tuser = tu; m_tready = rdy;
      #3;
      full_m = (q_commit.size() + q_pend.size()) == DEPTH;
      e_trdy = fm | ~full_m;
      free1  = ~slot_v[1] | rdy;
      free0  = ~slot_v[0] | free1;
      e_rv   = free0 && (q_commit.size() != 0);
      acc    = tv & e_trdy;
      wr     = acc & ~full_m & ~dropping;
      e_drop = fm & acc & tl & (tu | ~wr);
      chk("s_tready", d_trdy, e_trdy);
      chk("count", d_cnt, q_commit.size());
      chk("m_tvalid", d_tv, slot_v[1]);
      chk("valid_pipe", d_vp, {slot_v[1], slot_v[0]});
      chk("mem_r_v", d_rv, e_rv);
      chk("mem_w_v", d_wv, wr);
      chk("drop", d_drop, e_drop);
      chk("out_ready", d_ordy, rdy);
      // storage stand-in: data leaves in read order
      if (d_tv && rdy) begin
         n_out++;
         chk("out_q_nonempty", int'(dut_q.size() != 0), 1);
         if (dut_q.size() != 0) begin
            got = dut_q.pop_front();
            chk("out_data", got, slot_id[1]);
         end
      end
      if (d_rv) dut_q.push_back(bmem[d_raddr]);
      if (d_wv) bmem[d_waddr] = s_id;
      if (d_drop) n_drop++;
      // advance model
      if (slot_v[1] && rdy) slot_v[1] = 0;
      if (!slot_v[1]) begin
         slot_v[1] = slot_v[0]; slot_id[1] = slot_id[0]; slot_v[0] = 0;
      end
      if (e_rv) begin
         slot_v[0] = 1; slot_id[0] = q_commit.pop_front();
      end
      if (acc) begin
         if (wr) begin
            if (fm) q_pend.push_back(s_id);
            else    q_commit.push_back(s_id);
         end else if (fm) dropping = 1;
         if (fm && tl) begin
            if (tu || !wr) begin
               q_pend.delete(); dropping = 0;
            end else begin
               foreach (q_pend[i]) q_commit.push_back(q_pend[i]);
               q_pend.delete();
            end
         end
         s_id++;
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, rdy);
   endtask

   task automatic frame(input int len, input bit bad, input bit rdy);
      for (int i = 0; i < len; i++) cyc(1, i == len - 1, bad && (i == len - 1), rdy);
   endtask

   initial begin
      int o0, d0, s0;
      // ---------------- word mode ----------------
      fm = 1'b0;
      do_reset();
      cyc(0, 0, 0, 0);
      chk("rst_cnt", d_cnt, 0);
      chk("rst_trdy", d_trdy, 1);
      chk("rst_tv", d_tv, 0);
      chk("rst_rv", d_rv, 0);
      // fill with output stalled: 8 in storage plus 2 in the read pipeline
      o0 = n_out;
      for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0);
      chk("fill_cnt", d_cnt, 8);
      chk("fill_trdy", d_trdy, 0);
      idle(14, 1);
      chk("fill_drain_out", n_out - o0, 10);
      chk("fill_drain_cnt", d_cnt, 0);

      // ready toggling every cycle under a 20-word stream
      o0 = n_out; s0 = s_id;
      for (int i = 0; i < 60; i++) cyc((s_id - s0) < 20, 0, 0, (i % 2) == 0);
      idle(14, 1);
      chk("toggle_out", n_out - o0, 20);

      // full FIFO with concurrent read and write, pointers wrapping
      for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 0, 1);
         chk("full_rw_cnt", int'(d_cnt >= 7 && d_cnt <= 8), 1);
      end
      idle(14, 1);
      chk("full_rw_cnt_end", d_cnt, 0);

      // random traffic
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 3) != 0, 0, 0, $urandom_range(0, 2) != 0);
      idle(14, 1);
      chk("rand_word_cnt", d_cnt, 0);

      // ---------------- frame mode ----------------
      fm = 1'b1;
      do_reset();
      cyc(0, 0, 0, 1);
      chk("frst_cnt", d_cnt, 0);
      chk("frst_drop", d_drop, 0);
      // good 3-word frame: output valid two cycles after the commit becomes visible
      frame(3, 0, 1);
      cyc(0, 0, 0, 1);
      chk("frm_tv_c1", d_tv, 0);
      chk("frm_cnt_c1", d_cnt, 3);
      cyc(0, 0, 0, 1);
      chk("frm_tv_c2", d_tv, 0);
      cyc(0, 0, 0, 1);
      chk("frm_tv_c3", d_tv, 1);
      idle(8, 1);
      // bad frame: one drop, nothing emitted
      o0 = n_out; d0 = n_drop;
      frame(4, 1, 1);
      idle(8, 1);
      chk("bad_drop", n_drop - d0, 1);
      chk("bad_out", n_out - o0, 0);
      chk("bad_cnt", d_cnt, 0);
      // oversize frame always dropped, then a good frame still lands cleanly
      o0 = n_out; d0 = n_drop;
      frame(10, 0, 1);
      chk("big_drop", n_drop - d0, 1);
      idle(4, 1);
      chk("big_cnt", d_cnt, 0);
      frame(2, 0, 1);
      idle(8, 1);
      chk("big_then_good", n_out - o0, 2);

      // reset mid-frame with a committed frame held
      frame(5, 0, 0);
      frame(2, 0, 0);
      cyc(1, 0, 0, 0);
      do_reset();
      cyc(0, 0, 0, 0);
      chk("mid_rst_cnt", d_cnt, 0);
      chk("mid_rst_tv", d_tv, 0);
      o0 = n_out;
      frame(3, 0, 1);
      idle(8, 1);
      chk("post_rst_out", n_out - o0, 3);

      // random frames, with a stalled stretch to force overflow drops
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
             (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0));
      cyc(1, 1, 1, 1);
      idle(14, 1);
      chk("rand_frm_cnt", d_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
